// File: rtl/io_ports.sv
// I/O stage for the single-cycle CPU: an OUT FIFO draining to a device, plus four IN holding
// registers. Optional macro IO_BYPASS_EN forwards device data straight to a stalled IN.
module io_ports #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             out_we,
    input  logic [1:0]       out_sel,
    input  logic [WIDTH-1:0] out_data,
    input  logic             in_rd,
    input  logic [1:0]       in_sel,
    output logic [WIDTH-1:0] in_data,
    output logic             stall,
    output logic             ext_out_valid,
    output logic [1:0]       ext_out_port,
    output logic [WIDTH-1:0] ext_out_data,
    input  logic             ext_out_ready,
    input  logic             ext_in_valid,
    input  logic [1:0]       ext_in_port,
    input  logic [WIDTH-1:0] ext_in_data,
    output logic             ext_in_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Output FIFO state
    logic [WIDTH-1:0] fifo_data_q [DEPTH];
    logic [1:0]       fifo_port_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Input holding registers
    logic [WIDTH-1:0] hold_q [4];
    logic [3:0]       hflag_q, hflag_d;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic in_act;
    logic rd_hit;
    logic bypass;
    logic capture;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // Full is judged on the registered count, so a same-cycle pop never admits the push.
    assign push = reset & out_we & ~full;
    assign pop  = ext_out_valid & ext_out_ready;

    // OUT wins when both instructions are (illegally) asserted together.
    assign in_act = reset & in_rd & ~out_we;
    assign rd_hit = in_act & hflag_q[in_sel];

`ifdef IO_BYPASS_EN
    assign bypass = in_act & ~hflag_q[in_sel] & ext_in_valid & (ext_in_port == in_sel);
`else
    assign bypass = 1'b0;
`endif

    assign ext_in_ready = reset & (~hflag_q[ext_in_port] | bypass);
    assign capture      = ext_in_valid & ext_in_ready & ~bypass;

    always_comb begin
        stall = 1'b0;
        if (reset) begin
            stall = (out_we & full) | (in_act & ~hflag_q[in_sel] & ~bypass);
        end
    end

    always_comb begin
        in_data = '0;
        if (rd_hit) begin
            in_data = hold_q[in_sel];
        end else if (bypass) begin
            in_data = ext_in_data;
        end
    end

    always_comb begin
        ext_out_valid = reset & ~empty;
        ext_out_port  = '0;
        ext_out_data  = '0;
        if (ext_out_valid) begin
            ext_out_port = fifo_port_q[rd_ptr_q];
            ext_out_data = fifo_data_q[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        hflag_d = hflag_q;
        if (capture) begin
            hflag_d[ext_in_port] = 1'b1;
        end
        if (rd_hit) begin
            hflag_d[in_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hflag_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hflag_q  <= hflag_d;
        end
    end

    // Storage is never reset; only the pointers and flags define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= out_data;
            fifo_port_q[wr_ptr_q] <= out_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            hold_q[ext_in_port] <= ext_in_data;
        end
    end

endmodule

// File: tb/tb_io_ports.sv
// Table-driven bench for io_ports: one record per clock cycle holding the inputs and the
// expected combinational outputs just before the next rising edge.
module tb_io_ports;

    logic       clk;
    logic       reset;
    logic       out_we;
    logic [1:0] out_sel;
    logic [7:0] out_data;
    logic       in_rd;
    logic [1:0] in_sel;
    logic [7:0] in_data;
    logic       stall;
    logic       ext_out_valid;
    logic [1:0] ext_out_port;
    logic [7:0] ext_out_data;
    logic       ext_out_ready;
    logic       ext_in_valid;
    logic [1:0] ext_in_port;
    logic [7:0] ext_in_data;
    logic       ext_in_ready;

    io_ports #(.WIDTH(8), .DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .out_we        (out_we),
        .out_sel       (out_sel),
        .out_data      (out_data),
        .in_rd         (in_rd),
        .in_sel        (in_sel),
        .in_data       (in_data),
        .stall         (stall),
        .ext_out_valid (ext_out_valid),
        .ext_out_port  (ext_out_port),
        .ext_out_data  (ext_out_data),
        .ext_out_ready (ext_out_ready),
        .ext_in_valid  (ext_in_valid),
        .ext_in_port   (ext_in_port),
        .ext_in_data   (ext_in_data),
        .ext_in_ready  (ext_in_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       owe;
        logic [1:0] osel;
        logic [7:0] odat;
        logic       ird;
        logic [1:0] isel;
        logic       ordy;
        logic       ival;
        logic [1:0] iport;
        logic [7:0] idat;
        logic       e_stall;
        logic [7:0] e_ind;
        logic       e_ov;
        logic [1:0] e_op;
        logic [7:0] e_od;
        logic       e_ir;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_bad;

    task automatic add(input string name, input logic rst, input logic owe, input logic [1:0] osel,
                       input logic [7:0] odat, input logic ird, input logic [1:0] isel,
                       input logic ordy, input logic ival, input logic [1:0] iport,
                       input logic [7:0] idat, input logic e_stall, input logic [7:0] e_ind,
                       input logic e_ov, input logic [1:0] e_op, input logic [7:0] e_od,
                       input logic e_ir);
        vec_t v;
        v.name = name; v.rst = rst; v.owe = owe; v.osel = osel; v.odat = odat;
        v.ird = ird; v.isel = isel; v.ordy = ordy; v.ival = ival; v.iport = iport;
        v.idat = idat; v.e_stall = e_stall; v.e_ind = e_ind; v.e_ov = e_ov;
        v.e_op = e_op; v.e_od = e_od; v.e_ir = e_ir;
        vecs.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        reset         = v.rst;
        out_we        = v.owe;
        out_sel       = v.osel;
        out_data      = v.odat;
        in_rd         = v.ird;
        in_sel        = v.isel;
        ext_out_ready = v.ordy;
        ext_in_valid  = v.ival;
        ext_in_port   = v.iport;
        ext_in_data   = v.idat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        int         waited;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b0; out_we = 1'b0; out_sel = '0; out_data = '0; in_rd = 1'b0;
        in_sel = '0; ext_out_ready = 1'b0; ext_in_valid = 1'b0; ext_in_port = '0;
        ext_in_data = '0;

        //   name             rst owe osel odat  ird isel rdy ival ip idat   stl ind  ov op od   ir
        add("rst_hold0",       0, 1, 2, 8'h99, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00, 0);
        add("rst_hold1",       0, 1, 2, 8'h99, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00, 0);
        add("rst_rel_push",    1, 1, 2, 8'h99, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00, 1);
        add("rst_first_pop",   1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00,  0, 8'h00, 1, 2, 8'h99, 1);
        for (int i = 0; i < 4; i++) begin
            d = 8'h11 * 8'(i + 1);
            add("fill", 1, 1, 2, d, 0, 0, 0, 0, 0, 8'h00,
                0, 8'h00, i > 0, (i > 0) ? 2'd2 : 2'd0, (i > 0) ? 8'h11 : 8'h00, 1);
        end
        add("fill_full_stall", 1, 1, 2, 8'h55, 0, 0, 0, 0, 0, 8'h00,  1, 8'h00, 1, 2, 8'h11, 1);
        add("full_pop_nopush", 1, 1, 2, 8'h55, 0, 0, 1, 0, 0, 8'h00,  1, 8'h00, 1, 2, 8'h11, 1);
        add("push_after_pop",  1, 1, 2, 8'h55, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 1, 2, 8'h22, 1);
        for (int i = 0; i < 4; i++) begin
            d = 8'h11 * 8'(i + 2);
            add("drain", 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00, 0, 8'h00, 1, 2, d, 1);
        end
        add("drain_empty",     1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00, 1);
        for (int i = 0; i < 10; i++) begin
            add("wrap", 1, 1, 2'(i % 4), 8'(8'hA0 + i), 0, 0, 1, 0, 0, 8'h00,
                0, 8'h00, i > 0, (i > 0) ? 2'((i - 1) % 4) : 2'd0,
                (i > 0) ? 8'(8'hA0 + i - 1) : 8'h00, 1);
        end
        add("wrap_last",       1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 8'h00,  0, 8'h00, 1, 1, 8'hA9, 1);
        add("wrap_empty",      1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00, 1);
        add("in_cap_p1",       1, 0, 0, 8'h00, 0, 0, 0, 1, 1, 8'hA5,  0, 8'h00, 0, 0, 8'h00, 1);
        add("in_p1_busy",      1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 8'h00, 0);
        add("in_rd_p1",        1, 0, 0, 8'h00, 1, 1, 0, 0, 1, 8'h00,  0, 8'hA5, 0, 0, 8'h00, 0);
        add("in_p1_freed",     1, 0, 0, 8'h00, 0, 0, 0, 0, 1, 8'h00,  0, 8'h00, 0, 0, 8'h00, 1);
        add("in_empty_c1",     1, 0, 0, 8'h00, 1, 3, 0, 0, 3, 8'h00,  1, 8'h00, 0, 0, 8'h00, 1);
        add("in_empty_c2",     1, 0, 0, 8'h00, 1, 3, 0, 0, 3, 8'h00,  1, 8'h00, 0, 0, 8'h00, 1);
`ifdef IO_BYPASS_EN
        add("in_empty_c3",     1, 0, 0, 8'h00, 1, 3, 0, 1, 3, 8'h3C,  0, 8'h3C, 0, 0, 8'h00, 1);
        add("in_empty_c4",     1, 0, 0, 8'h00, 1, 3, 0, 0, 3, 8'h00,  1, 8'h00, 0, 0, 8'h00, 1);
`else
        add("in_empty_c3",     1, 0, 0, 8'h00, 1, 3, 0, 1, 3, 8'h3C,  1, 8'h00, 0, 0, 8'h00, 1);
        add("in_empty_c4",     1, 0, 0, 8'h00, 1, 3, 0, 0, 3, 8'h00,  0, 8'h3C, 0, 0, 8'h00, 0);
`endif
        add("in_p3_after",     1, 0, 0, 8'h00, 0, 0, 0, 0, 3, 8'h00,  0, 8'h00, 0, 0, 8'h00, 1);
        add("cap_p0",          1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 8'h5A,  0, 8'h00, 0, 0, 8'h00, 1);
        add("out_over_in",     1, 1, 0, 8'h77, 1, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00, 0);
        add("in_after_out",    1, 0, 0, 8'h00, 1, 0, 1, 0, 0, 8'h00,  0, 8'h5A, 1, 0, 8'h77, 0);
        add("prio_idle",       1, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00,  0, 8'h00, 0, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) begin
            add("rs_fill", 1, 1, 3, 8'(i + 1), 0, 0, 0, i == 0, 2, (i == 0) ? 8'hEE : 8'h00,
                0, 8'h00, i > 0, (i > 0) ? 2'd3 : 2'd0, (i > 0) ? 8'h01 : 8'h00, i == 0);
        end
        add("rs_stall",        1, 1, 3, 8'h05, 0, 0, 0, 0, 2, 8'h00,  1, 8'h00, 1, 3, 8'h01, 0);
        add("rs_assert",       0, 1, 3, 8'h05, 0, 0, 0, 0, 2, 8'h00,  0, 8'h00, 0, 0, 8'h00, 0);
        add("rs_after",        1, 0, 0, 8'h00, 1, 2, 0, 0, 2, 8'h00,  1, 8'h00, 0, 0, 8'h00, 1);
        add("rs_push",         1, 1, 1, 8'h66, 0, 0, 0, 0, 2, 8'h00,  0, 8'h00, 0, 0, 8'h00, 1);
        add("rs_pop",          1, 0, 0, 8'h00, 0, 0, 1, 0, 2, 8'h00,  0, 8'h00, 1, 1, 8'h66, 1);
        add("rs_empty",        1, 0, 0, 8'h00, 0, 0, 0, 0, 2, 8'h00,  0, 8'h00, 0, 0, 8'h00, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #2;
            n_vec++;
            if ({stall, in_data, ext_out_valid, ext_out_port, ext_out_data, ext_in_ready} !==
                {vecs[i].e_stall, vecs[i].e_ind, vecs[i].e_ov, vecs[i].e_op, vecs[i].e_od,
                 vecs[i].e_ir}) begin
                n_bad++;
                $display("FAIL %s #%0d: got stall=%b in_data=%h ov=%b op=%0d od=%h ir=%b, exp stall=%b in_data=%h ov=%b op=%0d od=%h ir=%b",
                         vecs[i].name, i, stall, in_data, ext_out_valid, ext_out_port,
                         ext_out_data, ext_in_ready, vecs[i].e_stall, vecs[i].e_ind,
                         vecs[i].e_ov, vecs[i].e_op, vecs[i].e_od, vecs[i].e_ir);
            end
        end

        // Hand sequence: one OUT, then a bounded wait for the head to appear.
        @(negedge clk);
        reset = 1'b1; out_we = 1'b1; out_sel = 2'd2; out_data = 8'hC3; in_rd = 1'b0;
        ext_out_ready = 1'b0; ext_in_valid = 1'b0;
        @(negedge clk);
        out_we = 1'b0;
        waited = 0;
        while (!ext_out_valid && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        #2;
        n_vec++;
        if (!ext_out_valid || ext_out_data !== 8'hC3 || ext_out_port !== 2'd2 || waited != 0) begin
            n_bad++;
            $display("FAIL hand_out_latency: got valid=%b port=%0d data=%h after %0d cycles, exp valid=1 port=2 data=c3 after 0",
                     ext_out_valid, ext_out_port, ext_out_data, waited);
        end
        ext_out_ready = 1'b1;
        @(negedge clk);
        ext_out_ready = 1'b0;
        #2;
        n_vec++;
        if (ext_out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hand_out_drained: got valid=%b, exp valid=0", ext_out_valid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/io_ports.md
# io_ports

Memory-mapped I/O stage for the single-cycle CPU. It sits between the datapath and external devices.
- OUT instructions push `{port, data}` into an output FIFO, which drains to the device over a valid/ready handshake.
- IN instructions read one of four per-port holding registers, each filled by the device through its own handshake.
- Read data feeds the register-file write-data mux.
- `stall` drives the PC register enable (`enable = ~stall`). It freezes the CPU when the FIFO is full or the addressed input port is empty.

## Interface
Parameters:
- `WIDTH`, default 8: data width.
- `DEPTH`, default 4: output FIFO entries. Must be a power of 2, ≥ 2.

Ports:
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: synchronous, active-low.
- `out_we` input, 1: CPU executes OUT this cycle.
- `out_sel` input, 2: OUT target port.
- `out_data` input, WIDTH: OUT data (register-file `rd1`).
- `in_rd` input, 1: CPU executes IN this cycle.
- `in_sel` input, 2: IN source port.
- `in_data` output, WIDTH: IN result to the write-data mux.
- `stall` output, 1: hold the PC and block register-file write.
- `ext_out_valid` output, 1: FIFO head valid.
- `ext_out_port` output, 2: head port number.
- `ext_out_data` output, WIDTH: head data.
- `ext_out_ready` input, 1: device accepts head.
- `ext_in_valid` input, 1: device offers data.
- `ext_in_port` input, 2: target holding register.
- `ext_in_data` input, WIDTH: offered data.
- `ext_in_ready` output, 1: the addressed holding register is empty.

## Operation
**Output FIFO**
- State: circular buffer of DEPTH entries, each `{2-bit port, WIDTH data}`.
- Pointers `wr_ptr` and `rd_ptr` are log2(DEPTH) bits and wrap modulo DEPTH.
- `count` ranges 0..DEPTH. `full` means `count == DEPTH`.
- Push = `out_we & ~full`. Pop = `ext_out_valid & ext_out_ready`.
- If `out_we & full`: assert `stall`, no push. `full` is evaluated from the current `count`, so a pop in the same cycle does not admit the push. The push happens the following cycle.
- Push and pop in the same cycle (not full, not empty): `count` is unchanged and both pointers advance.

**Input holding registers**
- Four registers `hold[0..3]`, each with a flag `hflag[0..3]`.
- `ext_in_ready = ~hflag[ext_in_port]`.
- Capture = `ext_in_valid & ext_in_ready`. On capture, set `hold[ext_in_port]` and `hflag[ext_in_port]`.

**IN instruction**
- If `in_rd & hflag[in_sel]`: `in_data = hold[in_sel]`, `stall = 0`, and `hflag[in_sel]` clears at the edge.
- If `in_rd & ~hflag[in_sel]`: `stall = 1`, `in_data = 0`.
- Same-edge capture and CPU read on the same port cannot occur, because `ext_in_ready` is low while the flag is set.

**`stall`**
- `stall = (out_we & full) | (in_rd & ~hflag[in_sel])`.
- `out_we` and `in_rd` are never both high. If both are high, OUT has priority and the IN is ignored that cycle.

**`in_data`**
- `in_data = 0` when `in_rd = 0`.

## Timing
- Reset at an edge with `reset = 0`: `count`, pointers and `hflag` all cleared. FIFO storage and `hold` are not cleared.
- Outputs while `reset = 0`: `stall = 0`, `ext_in_ready = 0`, `in_data = 0`, `ext_out_valid = 0`.
- Reset takes priority over any push, pop or capture in the same cycle. An in-flight stall is abandoned.
- `ext_out_port` and `ext_out_data` are 0 whenever `count == 0`.
- `ext_out_valid = (count != 0)`, derived from registers only.
- OUT latency: data pushed at edge N appears on `ext_out_*` after edge N when the FIFO was empty.
- `stall`, `in_data` and `ext_in_ready` are combinational from registers and current inputs.
- IN from an empty port with the device writing the same cycle (without bypass): stall one cycle, capture at the edge, read succeeds the next cycle.
- Handshake rule: the device must hold `ext_in_*` stable until `ext_in_ready` is seen high at an edge. The FIFO holds `ext_out_*` stable until the pop.

## Configuration
Macro: `IO_BYPASS_EN`.
- **Defined:** if `in_rd & ~hflag[in_sel] & ext_in_valid & (ext_in_port == in_sel)`:
  - `in_data = ext_in_data`, `stall = 0`;
  - `ext_in_ready = 1`;
  - the flag stays 0, because the data is consumed directly.
- **Not defined:** no bypass. That case stalls one cycle as described under Timing.

## Test plan
- **Reset:** hold `reset = 0` for 2 cycles with `out_we = 1` → `stall = 0`, `ext_out_valid = 0`, `count = 0`. Release → the first OUT is pushed.
- **FIFO fill and drain:** `ext_out_ready = 0`, issue five OUTs with data 0x11..0x55 on port 2.
  - First four push; the fifth sees `stall = 1`.
  - Raise `ext_out_ready` for one cycle → 0x11 is popped; 0x55 pushes the next cycle.
  - Drain order 0x11, 0x22, 0x33, 0x44, 0x55; `ext_out_port = 2` throughout.
- **Wrap-around:** 10 single push/pop pairs with `ext_out_ready = 1` → data arrives in order, `count` never exceeds 1, pointers wrap twice.
- **IN from a full port:** device writes 0xA5 to port 1 → `ext_in_ready` for port 1 drops. CPU `in_rd`, `in_sel = 1` → `in_data = 0xA5`, `stall = 0`. Next cycle `hflag[1] = 0`.
- **IN from an empty port:** CPU `in_rd` on port 3 with no device data → `stall = 1`, `in_data = 0` for 3 cycles. Device writes 0x3C at cycle 3:
  - without `IO_BYPASS_EN`: `in_data = 0x3C` at cycle 4;
  - with `IO_BYPASS_EN`: `in_data = 0x3C` at cycle 3 with `stall = 0`.
- **Reset mid-stall:** FIFO full, `out_we = 1`, assert reset → the next cycle has `count = 0` and `stall = 0`, and the pending OUT is not pushed.
